mips_mem_arbiter: RTL and testbench
===================================

Name: mips_mem_arbiter

Overview:
- Shares the single unified instruction/data memory between two masters.
  - Master 0: the multi-cycle MIPS core memory port.
  - Master 1: the program loader / debug master.
- Accepts one transaction at a time, issues it to memory, and returns read data with a valid strobe.
- Fixed priority to the core, with a starvation limit that forces a grant to the loader.
- Sits between both masters and the memory macro at the top of the system.

Parameters:
- ADDR_WIDTH, 32, memory word-address width (matches MIPS_PC_WIDTH).
- DATA_WIDTH, 32, data width (matches MIPS_DATA_WIDTH).
- MEM_LATENCY, 1, cycles from the issue cycle until mem_rdata is valid; legal range 1..15.
- MAX_WAIT, 8, number of lost arbitrations after which master 1 wins; legal range 1..255.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- m0_req  in  1  core request; held with its attributes until m0_gnt
- m0_we  in  1  core write (1) / read (0)
- m0_addr  in  ADDR_WIDTH  core address
- m0_wdata  in  DATA_WIDTH  core write data
- m0_gnt  out  1  one-cycle pulse, request accepted
- m0_rvalid  out  1  one-cycle pulse, m0_rdata valid
- m0_rdata  out  DATA_WIDTH  read data to core
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0_*, for the loader
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_we  out  1  memory write enable
- mem_rdata  in  DATA_WIDTH  memory read data

Behaviour:
- Interface: single clock clk; reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, wait_cnt=0, owner=0.
  - All gnt, rvalid, mem_we, mem_addr, mem_wdata and rdata outputs are 0.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Samples requests each cycle.
  - If any request is high, latch the winner's we/addr/wdata, set owner, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle):
  - mem_addr and mem_wdata carry the latched values.
  - mem_we = latched we.
  - gnt of the owner = 1.
  - Write: next state is IDLE.
  - Read: next state is WAIT, with the latency counter loaded to MEM_LATENCY.
- WAIT:
  - Decrement the counter each cycle.
  - When it reaches 0, capture mem_rdata into the owner's rdata register and go to RESP.
- RESP (1 cycle):
  - Owner's rvalid = 1.
  - Owner's rdata holds the captured word until the next read response for that master.
  - Next state is IDLE.
- Timing from request sampled in cycle N:
  - gnt and memory access occur in N+1.
  - Read: data is sampled from memory at N+1+MEM_LATENCY; rvalid is asserted at N+2+MEM_LATENCY.
  - Back-to-back accept rate: write 2 cycles; read MEM_LATENCY+3 cycles.
- Outside the ISSUE cycle:
  - mem_we = 0.
  - mem_addr and mem_wdata hold their last values.
- Arbitration (evaluated only in IDLE):
  - Only one request high: that master wins.
  - Both high and wait_cnt < MAX_WAIT: m0 wins, and wait_cnt increments (saturating at MAX_WAIT).
  - Both high and wait_cnt == MAX_WAIT: m1 wins.
  - wait_cnt clears to 0 whenever m1 is granted.
  - wait_cnt holds in all other cycles.
- Requests and their attributes arriving while not in IDLE are ignored until IDLE; a master must keep req high until its gnt.
- A requester deasserting req before gnt is legal; nothing is issued for it.
- Reset mid-transaction:
  - Return to IDLE on the next edge.
  - A pending rvalid is never produced.
  - mem_we drops to 0.
- rvalid is routed only to the owner master; the other master's rvalid stays 0.

Optional Feature:
- Macro: MIPS_MEM_ARB_RR_EN.
- Defined: MAX_WAIT and wait_cnt are unused. When both requests are high, the master not granted most recently wins. The last-granted register resets to 1, so m0 wins the first tie.
- Undefined: fixed priority with the starvation limit, as described in Behaviour.

Test Plan:
- m0 read addr 0x10, memory returns 0xDEADBEEF, MEM_LATENCY=1 → m0_gnt at N+1 with mem_addr=0x10 and mem_we=0; m0_rvalid at N+3 with m0_rdata=0xDEADBEEF; m1_rvalid stays 0.
- m1 write addr 0x20, data 0x12345678 → mem_we=1 for exactly one cycle (N+1) with mem_addr=0x20 and mem_wdata=0x12345678; m1_gnt in the same cycle; no rvalid.
- Both masters request continuously, MAX_WAIT=8 → m0 granted 8 times, then m1 once, then the pattern repeats.
- With MIPS_MEM_ARB_RR_EN defined, both request continuously → grants alternate m0, m1, m0, m1.
- rst_n=0 during WAIT of an m0 read → next cycle state is IDLE; no m0_rvalid ever appears; all outputs are 0.
- MEM_LATENCY=3, m0 read → m0_rvalid exactly at N+5; requests from m1 in cycles N+1..N+5 are not granted before N+6.

Source files
------------

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares one memory between the MIPS core (m0) and the loader (m1); define MIPS_MEM_ARB_RR_EN for round-robin ties.
module mips_mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1,
  parameter int MAX_WAIT    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t     state;
  logic       owner;
  logic       pick;
  logic [3:0] lat_cnt;
`ifdef MIPS_MEM_ARB_RR_EN
  logic       last_gnt;
  always_comb pick = m1_req & (~m0_req | ~last_gnt);
`else
  logic [7:0] wait_cnt;
  always_comb pick = m1_req & (~m0_req | (wait_cnt == 8'(MAX_WAIT)));
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= 1'b0;
      lat_cnt   <= '0;
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
`ifdef MIPS_MEM_ARB_RR_EN
      last_gnt  <= 1'b1;
`else
      wait_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (m0_req | m1_req) begin
          owner     <= pick;
          m0_gnt    <= ~pick;
          m1_gnt    <= pick;
          mem_we    <= pick ? m1_we : m0_we;
          mem_addr  <= pick ? m1_addr : m0_addr;
          mem_wdata <= pick ? m1_wdata : m0_wdata;
          state     <= ISSUE;
`ifdef MIPS_MEM_ARB_RR_EN
          last_gnt  <= pick;
`else
          // m1 requesting but not picked means m0 beat it on a tie
          if (pick) wait_cnt <= '0;
          else if (m1_req) wait_cnt <= wait_cnt + 8'd1;
`endif
        end
        ISSUE: begin
          m0_gnt  <= 1'b0;
          m1_gnt  <= 1'b0;
          mem_we  <= 1'b0;
          lat_cnt <= 4'(MEM_LATENCY);
          state   <= mem_we ? IDLE : WAIT;
        end
        WAIT: if (lat_cnt == 4'd1) begin
          if (owner) m1_rdata <= mem_rdata;
          else m0_rdata <= mem_rdata;
          m0_rvalid <= ~owner;
          m1_rvalid <= owner;
          state     <= RESP;
        end else lat_cnt <= lat_cnt - 4'd1;
        RESP: begin
          m0_rvalid <= 1'b0;
          m1_rvalid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb_mips_mem_arbiter: directed checks of the arbiter at MEM_LATENCY 1 (u1) and 3 (u3).
module tb_mips_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0, mem_rdata = '0;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_we;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata;
  logic        m0_gnt3, m0_rvalid3, m1_gnt3, m1_rvalid3, mem_we3;
  logic [31:0] m0_rdata3, m1_rdata3, mem_addr3, mem_wdata3;
  int          checks = 0;
  int          failures = 0;
  logic        exp_m1;

  always #5 clk = ~clk;

  mips_mem_arbiter #(.MEM_LATENCY(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  mips_mem_arbiter #(.MEM_LATENCY(3)) u3 (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt3), .m0_rvalid(m0_rvalid3), .m0_rdata(m0_rdata3),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt3), .m1_rvalid(m1_rvalid3), .m1_rdata(m1_rdata3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_we(mem_we3), .mem_rdata(mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_m0_gnt"}, {31'd0, m0_gnt}, 32'd0);
    chk({tag, "_m1_gnt"}, {31'd0, m1_gnt}, 32'd0);
    chk({tag, "_m0_rvalid"}, {31'd0, m0_rvalid}, 32'd0);
    chk({tag, "_m1_rvalid"}, {31'd0, m1_rvalid}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_m0_rdata"}, m0_rdata, 32'd0);
    chk({tag, "_m1_rdata"}, m1_rdata, 32'd0);
  endtask

  initial begin
    tick();
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();
    // m0 read of 0x10, latency 1
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    tick();
    chk("rd_m0_gnt", {31'd0, m0_gnt}, 32'd1);
    chk("rd_m1_gnt", {31'd0, m1_gnt}, 32'd0);
    chk("rd_mem_addr", mem_addr, 32'h10);
    chk("rd_mem_we", {31'd0, mem_we}, 32'd0);
    m0_req = 1'b0;
    mem_rdata = 32'hDEADBEEF;
    tick();
    chk("rd_wait_rvalid", {31'd0, m0_rvalid}, 32'd0);
    chk("rd_wait_gnt", {31'd0, m0_gnt}, 32'd0);
    tick();
    chk("rd_m0_rvalid", {31'd0, m0_rvalid}, 32'd1);
    chk("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
    chk("rd_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
    mem_rdata = 32'h0;
    tick();
    chk("rd_rvalid_pulse", {31'd0, m0_rvalid}, 32'd0);
    chk("rd_rdata_hold", m0_rdata, 32'hDEADBEEF);
    // m1 write of 0x12345678 to 0x20
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h12345678;
    tick();
    chk("wr_mem_we", {31'd0, mem_we}, 32'd1);
    chk("wr_mem_addr", mem_addr, 32'h20);
    chk("wr_mem_wdata", mem_wdata, 32'h12345678);
    chk("wr_m1_gnt", {31'd0, m1_gnt}, 32'd1);
    chk("wr_m0_gnt", {31'd0, m0_gnt}, 32'd0);
    m1_req = 1'b0;
    tick();
    chk("wr_mem_we_drop", {31'd0, mem_we}, 32'd0);
    chk("wr_mem_addr_hold", mem_addr, 32'h20);
    chk("wr_mem_wdata_hold", mem_wdata, 32'h12345678);
    chk("wr_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
    tick();
    chk("wr_m1_rvalid2", {31'd0, m1_rvalid}, 32'd0);
    // both masters issue writes continuously
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h30;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h40;
    for (int k = 0; k < 18; k++) begin
      tick();
`ifdef MIPS_MEM_ARB_RR_EN
      exp_m1 = (k % 2) == 1;
`else
      exp_m1 = (k % 9) == 8;
`endif
      chk($sformatf("arb_m1_gnt_%0d", k), {31'd0, m1_gnt}, {31'd0, exp_m1});
      chk($sformatf("arb_m0_gnt_%0d", k), {31'd0, m0_gnt}, {31'd0, ~exp_m1});
      chk($sformatf("arb_mem_addr_%0d", k), mem_addr, exp_m1 ? 32'h40 : 32'h30);
      tick();
    end
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
    chk("arb_idle_m0_gnt", {31'd0, m0_gnt}, 32'd0);
    chk("arb_idle_m1_gnt", {31'd0, m1_gnt}, 32'd0);
    // reset in the WAIT state of an m0 read
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h14;
    tick();
    chk("rst_rd_gnt", {31'd0, m0_gnt}, 32'd1);
    m0_req = 1'b0;
    mem_rdata = 32'hCAFEF00D;
    tick();
    chk("rst_rd_wait", {31'd0, m0_rvalid}, 32'd0);
    rst_n = 1'b0;
    tick();
    chk_all_zero("rst_mid");
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("rst_no_rvalid_%0d", k), {31'd0, m0_rvalid}, 32'd0);
      chk($sformatf("rst_rdata_%0d", k), m0_rdata, 32'd0);
    end
    // latency 3 read on u3 with m1 queued behind it
    mem_rdata = 32'h0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h44;
    tick();
    chk("l3_m0_gnt", {31'd0, m0_gnt3}, 32'd1);
    chk("l3_mem_addr", mem_addr3, 32'h44);
    m0_req = 1'b0;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h50; m1_wdata = 32'h5;
    mem_rdata = 32'hA5A5A5A5;
    for (int k = 2; k <= 4; k++) begin
      tick();
      chk($sformatf("l3_rvalid_n%0d", k), {31'd0, m0_rvalid3}, 32'd0);
      chk($sformatf("l3_m1_gnt_n%0d", k), {31'd0, m1_gnt3}, 32'd0);
    end
    tick();
    chk("l3_rvalid_n5", {31'd0, m0_rvalid3}, 32'd1);
    chk("l3_rdata_n5", m0_rdata3, 32'hA5A5A5A5);
    chk("l3_m1_rvalid_n5", {31'd0, m1_rvalid3}, 32'd0);
    chk("l3_m1_gnt_n5", {31'd0, m1_gnt3}, 32'd0);
    tick();
    chk("l3_rvalid_n6", {31'd0, m0_rvalid3}, 32'd0);
    chk("l3_m1_gnt_n6", {31'd0, m1_gnt3}, 32'd0);
    tick();
    chk("l3_m1_gnt_n7", {31'd0, m1_gnt3}, 32'd1);
    chk("l3_mem_we_n7", {31'd0, mem_we3}, 32'd1);
    chk("l3_mem_addr_n7", mem_addr3, 32'h50);
    m1_req = 1'b0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
